pipeif_fetch: RTL and testbench
===============================

# pipeif_fetch

Instruction-fetch stage of the 5-stage pipelined CPU, directly upstream of the decode stage. It owns the PC register and the next-PC select driven by decode's `pcsource`/`bpc`/`jpc`/`ra`. It fetches from an instruction memory with a valid/ready handshake and variable wait states. It drives the IF/ID pipeline register (`dpc4`, `inst`) consumed by decode, and honours decode's `nostall` and the single branch delay slot.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value after reset
- `clk`  in  1  clock; all state updates on rising edge
- `clrn`  in  1  asynchronous active-low reset
- `bpc`  in  32  branch target from decode
- `jpc`  in  32  jump target from decode
- `ra`  in  32  register target for jr, forwarded operand from decode
- `pcsource`  in  2  next-PC select: 00 pc+4, 01 bpc, 10 ra, 11 jpc
- `nostall`  in  1  1 = decode accepts a new IF/ID value this cycle
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  32  fetch address, equal to `pc`
- `imem_rdy`  in  1  memory response valid this cycle
- `imem_rdata`  in  32  instruction word, valid when `imem_req & imem_rdy`
- `pc`  out  32  current fetch PC
- `dpc4`  out  32  IF/ID: address of fetched instruction + 4
- `inst`  out  32  IF/ID: instruction; 32'h0 (sll $0 = nop) for a bubble
- `dvalid`  out  1  IF/ID: 1 = `inst` is a real fetched instruction

## Operation
- Internal state: `pc`, the IF/ID registers (`dpc4`, `inst`, `dvalid`), the hold buffer (`hold_valid`, `hold_inst`), and the redirect buffer (`redir_pending`, `redir_pc`).
- `imem_req = clrn & ~hold_valid`. `imem_addr = pc`. At most one request is outstanding. `pc` stays stable while `imem_req` is high and `imem_rdy` is low.
- `fire = imem_req & imem_rdy`. `have = fire | hold_valid`. `inst_in = hold_valid ? hold_inst : imem_rdata`.
- `pc4 = pc + 32'd4`. Addition is modulo 2^32, so `32'hFFFF_FFFC + 4` wraps to 0.
- Select target `sel` by `pcsource`: 00 `pc4`, 01 `bpc`, 10 `ra`, 11 `jpc`.
- `npc = redir_pending ? redir_pc : sel`.
- IF/ID update when `nostall = 1`:
  - If `have`: load `dpc4 <= pc4`, `inst <= inst_in`, `dvalid <= 1`.
  - Otherwise insert a bubble: `inst <= 0`, `dvalid <= 0`, `dpc4 <= pc4`.
- IF/ID update when `nostall = 0`: IF/ID holds. If `fire`, capture into the hold buffer: `hold_valid <= 1`, `hold_inst <= imem_rdata`.
- Hold buffer clears (`hold_valid <= 0`) whenever `hold_valid & nostall`.
- PC update: `pc <= npc` only when `have & nostall`. This is when the instruction at `pc`, normally the delay slot of a branch in decode, enters IF/ID. On that update `redir_pending <= 0`.
- Redirect capture:
  - If `nostall & ~have & pcsource != 00 & ~redir_pending`, then `redir_pending <= 1`, `redir_pc <= sel`.
  - Purpose: the branch leaves decode while its delay slot is still being fetched, so its target is saved.
- `redir_pending` has priority over `pcsource`. Decode sees only bubbles until the delay slot arrives.
- Delay slot: the instruction at branch address + 4 is always delivered. There is no squash.

## Timing
- Reset (async, `clrn = 0`): `pc = RESET_PC`, `dpc4 = 0`, `inst = 0`, `dvalid = 0`, `hold_valid = 0`, `redir_pending = 0`, `imem_req = 0`.
- First request appears in the first cycle with `clrn = 1`, with `imem_addr = RESET_PC`.
- Zero-wait memory (`imem_rdy` tied high, `nostall = 1`): one instruction per cycle. Fetched at cycle N, the instruction is visible on `inst` at cycle N+1.
- Each cycle with `imem_rdy = 0` inserts one bubble into decode when `nostall = 1`.
- Stall during fetch: the response is captured in the hold buffer and `imem_req` drops the next cycle. The held word enters IF/ID in the first cycle with `nostall = 1`; `pc` advances on that same edge.
- `fire` and `nostall` in the same cycle: the data goes straight to IF/ID and the hold buffer stays empty.
- Reset mid-request: the request is abandoned. A response arriving after `clrn` rises is accepted only if `imem_req` is high, and it belongs to `RESET_PC`.

## Test plan
- Reset then `imem_rdy = 1`, mem[i] = i, `nostall = 1`, `pcsource = 00` -> `imem_addr` 0, 4, 8…; `inst` = 0, 4, 8… on consecutive cycles; `dpc4 = addr + 4`; `dvalid = 1` from the second cycle.
- `imem_rdy` low for 3 cycles at addr 8 -> three `inst = 0`, `dvalid = 0` bubbles, then mem[8] with `dpc4 = 12`; `pc` holds 8 throughout the wait.
- `nostall = 0` for 2 cycles while the fetch at 12 completes -> `imem_req` drops after capture; IF/ID holds; on `nostall = 1`, `inst` = mem[12] and `pc` becomes 16.
- Branch in decode with `pcsource = 01`, `bpc = 32'h100`, fetch at 20 with `imem_rdy = 1` -> `inst` = mem[20] (delay slot), next `imem_addr = 32'h100`.
- Same branch but fetch at 20 waits 2 cycles -> `redir_pending` set; `pcsource` returns to 00; when mem[20] arrives, `pc` becomes `32'h100`, not 24.
- `pcsource = 10`, `ra = 32'h40`, and separately `pc = 32'hFFFF_FFFC` with `pcsource = 00` -> next `pc` = 32'h40 and 32'h0 respectively; assert `clrn` low mid-wait -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/pipeif_fetch.sv
// Instruction-fetch stage: PC register, next-PC select, instruction-memory handshake and IF/ID register.
// A word fetched while decode stalls is parked in a hold buffer; a branch target whose delay slot is still in flight is parked in a redirect buffer.
module pipeif_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic [31:0] bpc,
   input  logic [31:0] jpc,
   input  logic [31:0] ra,
   input  logic [1:0]  pcsource,
   input  logic        nostall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rdy,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] dpc4,
   output logic [31:0] inst,
   output logic        dvalid
);

   logic [31:0] r_pc;
   logic [31:0] r_dpc4;
   logic [31:0] r_inst;
   logic        r_dvalid;
   logic        r_hold_valid;
   logic [31:0] r_hold_inst;
   logic        r_redir_pending;
   logic [31:0] r_redir_pc;

   logic        w_fire;
   logic        w_have;
   logic [31:0] w_inst_in;
   logic [31:0] w_pc4;
   logic [31:0] w_sel;
   logic [31:0] w_npc;

   // A parked word blocks new requests, so at most one fetch is ever outstanding.
   assign imem_req  = clrn & ~r_hold_valid;
   assign imem_addr = r_pc;
   assign w_fire    = imem_req & imem_rdy;
   assign w_have    = w_fire | r_hold_valid;
   assign w_inst_in = r_hold_valid ? r_hold_inst : imem_rdata;
   assign w_pc4     = r_pc + 32'd4;

   always_comb begin
      w_sel = w_pc4;
      unique case (pcsource)
         2'b00: w_sel = w_pc4;
         2'b01: w_sel = bpc;
         2'b10: w_sel = ra;
         2'b11: w_sel = jpc;
      endcase
   end

   assign w_npc = r_redir_pending ? r_redir_pc : w_sel;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_pc            <= RESET_PC;
         r_dpc4          <= 32'd0;
         r_inst          <= 32'd0;
         r_dvalid        <= 1'b0;
         r_hold_valid    <= 1'b0;
         r_redir_pending <= 1'b0;
      end else if (nostall) begin
         r_dpc4       <= w_pc4;
         r_dvalid     <= w_have;
         r_inst       <= w_have ? w_inst_in : 32'd0;
         r_hold_valid <= 1'b0;
         // PC only moves when the instruction at pc (the delay slot) enters IF/ID.
         if (w_have) begin
            r_pc            <= w_npc;
            r_redir_pending <= 1'b0;
         end else if (pcsource != 2'b00 && !r_redir_pending) begin
            r_redir_pending <= 1'b1;
         end
      end else if (w_fire) begin
         r_hold_valid <= 1'b1;
      end
   end

   // Payload of the hold and redirect buffers; qualified by their valid flags, so no reset.
   always_ff @(posedge clk) begin
      if (!nostall && w_fire)
         r_hold_inst <= imem_rdata;
      if (nostall && !w_have && pcsource != 2'b00 && !r_redir_pending)
         r_redir_pc <= w_sel;
   end

   assign pc     = r_pc;
   assign dpc4   = r_dpc4;
   assign inst   = r_inst;
   assign dvalid = r_dvalid;

endmodule

// File: tb/tb_pipeif_fetch.sv
// Bench for pipeif_fetch: directed scenarios plus randomized handshake/stall/redirect traffic,
// checked every cycle against a transaction-level model of what decode should receive.
module tb_pipeif_fetch;

   logic        clk = 1'b0;
   logic        clrn;
   logic [31:0] bpc, jpc, ra;
   logic [1:0]  pcsource;
   logic        nostall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rdy;
   logic [31:0] imem_rdata;
   logic [31:0] pc, dpc4, inst;
   logic        dvalid;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] mem_key = 32'h0;

   pipeif_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .clrn(clrn), .bpc(bpc), .jpc(jpc), .ra(ra),
      .pcsource(pcsource), .nostall(nostall),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy),
      .imem_rdata(imem_rdata), .pc(pc), .dpc4(dpc4), .inst(inst), .dvalid(dvalid)
   );

   always #5 clk = ~clk;

   // Instruction memory contents: the word at address a.
   function automatic logic [31:0] memw(input logic [31:0] a);
      return a ^ mem_key;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: the fetch address, what decode currently holds, an already
   // fetched-but-undelivered word, and a remembered branch destination.
   logic [31:0] m_fetch_addr;
   logic [31:0] m_id_pc4, m_id_inst;
   logic        m_id_real;
   logic        m_parked;
   logic [31:0] m_parked_word;
   logic        m_dest_known;
   logic [31:0] m_dest;

   task automatic model_reset();
      m_fetch_addr = 32'h0;
      m_id_pc4     = 32'h0;
      m_id_inst    = 32'h0;
      m_id_real    = 1'b0;
      m_parked     = 1'b0;
      m_dest_known = 1'b0;
   endtask

   task automatic check_outputs();
      chk("imem_req",  {31'd0, imem_req}, {31'd0, ~m_parked});
      chk("imem_addr", imem_addr, m_fetch_addr);
      chk("pc",        pc,        m_fetch_addr);
      chk("dpc4",      dpc4,      m_id_pc4);
      chk("inst",      inst,      m_id_inst);
      chk("dvalid",    {31'd0, dvalid}, {31'd0, m_id_real});
   endtask

   // One clock cycle: drive inputs at the falling edge, check, then advance the model.
   task automatic tick(input bit rdy, input bit ns, input logic [1:0] ps);
      bit          got_word;
      logic [31:0] word, wanted;
      imem_rdy   = rdy;
      nostall    = ns;
      pcsource   = ps;
      imem_rdata = rdy ? memw(imem_addr) : $urandom;
      #1;
      check_outputs();
      got_word = m_parked || rdy;
      word     = m_parked ? m_parked_word : memw(m_fetch_addr);
      case (ps)
         2'b01:   wanted = bpc;
         2'b10:   wanted = ra;
         2'b11:   wanted = jpc;
         default: wanted = m_fetch_addr + 32'd4;
      endcase
      if (m_dest_known) wanted = m_dest;
      if (ns) begin
         m_id_pc4  = m_fetch_addr + 32'd4;
         m_id_real = got_word;
         m_id_inst = got_word ? word : 32'h0;
         m_parked  = 1'b0;
         if (got_word) begin
            m_fetch_addr = wanted;
            m_dest_known = 1'b0;
         end else if (ps != 2'b00 && !m_dest_known) begin
            m_dest_known = 1'b1;
            m_dest       = wanted;
         end
      end else if (got_word && !m_parked) begin
         m_parked      = 1'b1;
         m_parked_word = word;
      end
      @(negedge clk);
   endtask

   initial begin
      clrn = 1'b0; bpc = '0; jpc = '0; ra = '0; pcsource = 2'b00;
      nostall = 1'b1; imem_rdy = 1'b0; imem_rdata = '0;
      model_reset();
      @(negedge clk);
      #1;
      chk("rst_pc", pc, 32'h0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_dvalid", {31'd0, dvalid}, 32'd0);
      chk("rst_dpc4", dpc4, 32'h0);
      @(negedge clk);
      clrn = 1'b1;

      // Zero-wait streaming from RESET_PC.
      repeat (2) tick(1, 1, 2'b00);
      chk("stream_inst4", inst, 32'h4);
      chk("stream_dpc4", dpc4, 32'h8);
      // Three wait states at 8, then the word arrives.
      repeat (3) tick(0, 1, 2'b00);
      chk("wait_pc", pc, 32'h8);
      tick(1, 1, 2'b00);
      chk("wait_inst8", inst, 32'h8);
      chk("wait_dpc4", dpc4, 32'hC);
      // Decode stall while the fetch at 12 completes.
      tick(1, 0, 2'b00);
      tick(1, 0, 2'b00);
      tick(0, 1, 2'b00);
      chk("hold_inst", inst, 32'hC);
      chk("hold_pc", pc, 32'h10);
      tick(1, 1, 2'b00);
      // Branch with the delay slot at 20 returned immediately.
      bpc = 32'h100;
      tick(1, 1, 2'b01);
      chk("br_slot", inst, 32'h14);
      chk("br_pc", pc, 32'h100);
      // Branch whose delay slot at 0x104 waits two cycles.
      bpc = 32'h200;
      tick(1, 1, 2'b00);
      tick(0, 1, 2'b01);
      tick(0, 1, 2'b00);
      tick(1, 1, 2'b00);
      chk("redir_pc", pc, 32'h200);
      chk("redir_slot", inst, 32'h104);
      // Register target and PC wraparound.
      ra = 32'h40;
      tick(1, 1, 2'b10);
      chk("jr_pc", pc, 32'h40);
      jpc = 32'hFFFF_FFFC;
      tick(1, 1, 2'b11);
      tick(1, 1, 2'b00);
      chk("wrap_pc", pc, 32'h0);
      // Asynchronous reset in the middle of a wait.
      tick(0, 1, 2'b00);
      imem_rdy = 1'b0;
      clrn = 1'b0;
      #1;
      model_reset();
      chk("mid_rst_pc", pc, 32'h0);
      chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
      chk("mid_rst_inst", inst, 32'h0);
      chk("mid_rst_dvalid", {31'd0, dvalid}, 32'd0);
      chk("mid_rst_dpc4", dpc4, 32'h0);
      @(negedge clk);
      clrn = 1'b1;

      // Randomized traffic with a distinct memory image.
      mem_key = 32'h5A5A_0000;
      for (int i = 0; i < 500; i++) begin
         bpc = {$urandom_range(0, 1023), 2'b00};
         jpc = {$urandom, 2'b00} ;
         ra  = {$urandom_range(0, 4095), 2'b00};
         tick(($urandom % 4) != 0, ($urandom % 5) != 0,
              (($urandom % 6) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, limit %0d ns", 200000);
      $fatal(1);
   end

endmodule
